hub75_scan_ctrl: RTL and testbench

- Downstream neighbour of fm6126init. Owns the HUB75 panel pins once FM6126A register init completes.
- Scans one half-panel row at a time: prefetches pixels from the frame buffer, shifts columns out, blanks, latches, then displays for a fixed on-time.
- While init holds mask_en high, init's rgb1/rgb2/latch/clk pass through to the panel and scanning is held off.

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 scan controller: scan FSM states, pixel colour
// type and a counter-width helper that never returns zero.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_t;

  typedef logic [2:0] rgb_t;

  // Width for a counter/address covering n distinct values (minimum 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row scanner: prefetch, shift, blank, latch and display one half-panel
// row at a time; yields the panel pins to the FM6126A init block while mask_en.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | init owns the panel, scan outputs parked
// PREFETCH | present column 0 / current row to the frame buffer
// SHIFT    | two cycles per column: A = clk low, B = clk high
// BLANK    | clk and data low, outputs disabled
// LATCH    | latch pulse, row select follows the shifted row
// DISPLAY  | oe_n low for OE_CYCLES cycles, then next row
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int PANEL_WIDTH = 64,
  parameter int PANEL_ROWS  = 16,
  parameter int OE_CYCLES   = 256
) (
  input  logic                              clk_in,
  input  logic                              reset,
  input  logic                              mask_en,
  input  logic [2:0]                        init_rgb1,
  input  logic [2:0]                        init_rgb2,
  input  logic                              init_latch,
  input  logic                              init_clk,
  output logic [cnt_width(PANEL_WIDTH)-1:0] col_addr,
  output logic [cnt_width(PANEL_ROWS)-1:0]  row_addr,
  input  logic [2:0]                        pixel_rgb1,
  input  logic [2:0]                        pixel_rgb2,
  output logic                              clk_out,
  output logic [2:0]                        rgb1_out,
  output logic [2:0]                        rgb2_out,
  output logic                              latch_out,
  output logic                              oe_n_out,
  output logic [cnt_width(PANEL_ROWS)-1:0]  row_out,
  output logic                              frame_done
);

  localparam int CW = cnt_width(PANEL_WIDTH);
  localparam int RW = cnt_width(PANEL_ROWS);
  localparam int OW = cnt_width(OE_CYCLES + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(PANEL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PANEL_ROWS - 1);
  localparam logic [OW-1:0] OE_LOAD  = OW'(OE_CYCLES);
  localparam logic [OW-1:0] OE_LAST  = OW'(1);

  scan_state_t   state_q, state_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d, row_next;
  logic [OW-1:0] oe_cnt_q, oe_cnt_d;
  logic [CW-1:0] col_addr_d;
  logic [RW-1:0] row_addr_d;
  logic [RW-1:0] row_sel_q, row_sel_d;
  rgb_t          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic          clk_q, clk_d;
  logic          latch_q, latch_d;
  logic          oe_n_q, oe_n_d;
  logic          frame_done_q, frame_done_d;

  assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    row_d      = row_q;
    oe_cnt_d   = oe_cnt_q;
    col_addr_d = col_addr;
    row_addr_d = row_addr;
    row_sel_d  = row_sel_q;
    rgb1_d     = rgb1_q;
    rgb2_d     = rgb2_q;

    if (mask_en) begin
      // Init has taken the bus back: drop the partial frame entirely.
      state_d    = IDLE;
      phase_d    = 1'b0;
      col_d      = '0;
      row_d      = '0;
      oe_cnt_d   = '0;
      col_addr_d = '0;
      row_addr_d = '0;
      row_sel_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = PREFETCH;
          row_d      = '0;
          col_addr_d = '0;
          row_addr_d = '0;
        end
        PREFETCH: begin
          state_d = SHIFT;
          phase_d = 1'b0;
          col_d   = '0;
        end
        SHIFT: begin
          if (!phase_q) begin
            phase_d    = 1'b1;
            rgb1_d     = pixel_rgb1;
            rgb2_d     = pixel_rgb2;
            col_addr_d = (col_q == COL_LAST) ? col_q : col_q + 1'b1;
          end else if (col_q == COL_LAST) begin
            state_d = BLANK;
          end else begin
            phase_d = 1'b0;
            col_d   = col_q + 1'b1;
          end
        end
        BLANK: state_d = LATCH;
        LATCH: begin
          state_d   = DISPLAY;
          oe_cnt_d  = OE_LOAD;
          row_sel_d = row_q;
        end
        DISPLAY: begin
          if (oe_cnt_q == OE_LAST) begin
            // Address the next row already; row_out keeps the lit row.
            state_d    = PREFETCH;
            row_d      = row_next;
            row_addr_d = row_next;
            col_addr_d = '0;
          end else begin
            oe_cnt_d = oe_cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != SHIFT) begin
      rgb1_d = '0;
      rgb2_d = '0;
    end

    // Panel pins are registered from the upcoming state so they are glitch-free.
    clk_d        = (state_d == SHIFT) && phase_d;
    latch_d      = (state_d == LATCH);
    oe_n_d       = (state_d != DISPLAY);
    frame_done_d = (state_d == DISPLAY) && (oe_cnt_d == OE_LAST) && (row_q == ROW_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      oe_cnt_q     <= '0;
      col_addr     <= '0;
      row_addr     <= '0;
      row_sel_q    <= '0;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      clk_q        <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      row_q        <= row_d;
      oe_cnt_q     <= oe_cnt_d;
      col_addr     <= col_addr_d;
      row_addr     <= row_addr_d;
      row_sel_q    <= row_sel_d;
      rgb1_q       <= rgb1_d;
      rgb2_q       <= rgb2_d;
      clk_q        <= clk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rgb1_out   = mask_en ? init_rgb1  : rgb1_q;
  assign rgb2_out   = mask_en ? init_rgb2  : rgb2_q;
  assign latch_out  = mask_en ? init_latch : latch_q;
  assign clk_out    = mask_en ? init_clk   : clk_q;
  assign oe_n_out   = mask_en ? 1'b1       : oe_n_q;
  assign row_out    = row_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: small panel checked every cycle against a
// timeline model, plus a default-size instance checked for frame/row periods.
module tb_hub75_scan_ctrl;

  localparam int W    = 4;
  localparam int ROWS = 2;
  localparam int OE   = 8;
  localparam int P    = 2 * W + OE + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mask_en;
  logic [2:0] init_rgb1, init_rgb2;
  logic       init_latch, init_clk;
  logic [1:0] col_addr;
  logic [0:0] row_addr;
  logic [2:0] pixel_rgb1 = '0, pixel_rgb2 = '0;
  logic       clk_out, latch_out, oe_n_out, frame_done;
  logic [2:0] rgb1_out, rgb2_out;
  logic [0:0] row_out;

  hub75_scan_ctrl #(.PANEL_WIDTH(W), .PANEL_ROWS(ROWS), .OE_CYCLES(OE)) dut (
    .clk_in(clk), .reset(reset), .mask_en(mask_en),
    .init_rgb1(init_rgb1), .init_rgb2(init_rgb2),
    .init_latch(init_latch), .init_clk(init_clk),
    .col_addr(col_addr), .row_addr(row_addr),
    .pixel_rgb1(pixel_rgb1), .pixel_rgb2(pixel_rgb2),
    .clk_out(clk_out), .rgb1_out(rgb1_out), .rgb2_out(rgb2_out),
    .latch_out(latch_out), .oe_n_out(oe_n_out), .row_out(row_out),
    .frame_done(frame_done)
  );

  // Default-size instance, never masked.
  logic       rst_d, mask_en_d;
  logic [5:0] col_addr_d;
  logic [3:0] row_addr_d, row_out_d;
  logic [2:0] pix_d1 = '0, pix_d2 = '0, rgb1_d, rgb2_d;
  logic       clk_out_d, latch_d, oe_n_d, frame_done_d;

  hub75_scan_ctrl dut_def (
    .clk_in(clk), .reset(rst_d), .mask_en(mask_en_d),
    .init_rgb1(init_rgb1), .init_rgb2(init_rgb2),
    .init_latch(init_latch), .init_clk(init_clk),
    .col_addr(col_addr_d), .row_addr(row_addr_d),
    .pixel_rgb1(pix_d1), .pixel_rgb2(pix_d2),
    .clk_out(clk_out_d), .rgb1_out(rgb1_d), .rgb2_out(rgb2_d),
    .latch_out(latch_d), .oe_n_out(oe_n_d), .row_out(row_out_d),
    .frame_done(frame_done_d)
  );

  int n_vec = 0, n_bad = 0;
  int ecnt = 0;
  int m_t = 0;
  bit m_idle = 1'b1, m_valid = 1'b0;

  int rise_q[$], latch_q[$], fd_q[$], dfd_q[$], drow_q[$];
  int oe_low = 0;
  logic prev_clk = 1'b0;
  logic [3:0] prev_drow = '0;

  function automatic int f1(input int r, input int c);
    return c & 7;
  endfunction

  function automatic int f2(input int r, input int c);
    return (r * 4 + c) & 7;
  endfunction

  function automatic int qv(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0d, expected %0d", name, ecnt, act, exp);
    end
  endtask

  // Frame buffers: one-cycle synchronous read latency.
  initial begin
    int ca, ra;
    forever begin
      @(negedge clk);
      ca = int'(col_addr);
      ra = int'(row_addr);
      @(posedge clk);
      #1;
      pixel_rgb1 = 3'(f1(ra, ca));
      pixel_rgb2 = 3'(f2(ra, ca));
    end
  end

  initial begin
    int ca;
    forever begin
      @(negedge clk);
      ca = int'(col_addr_d);
      @(posedge clk);
      #1;
      pix_d1 = 3'(ca & 7);
      pix_d2 = 3'((ca >> 3) & 7);
    end
  end

  // Model: m_t is cycles since the scan started at PREFETCH of row 0.
  always @(posedge clk) begin
    ecnt++;
    if (reset) begin
      m_valid = 1'b1;
      m_idle  = 1'b1;
      m_t     = 0;
    end else if (m_idle) begin
      if (!mask_en) begin
        m_idle = 1'b0;
        m_t    = 0;
      end
    end else if (mask_en) begin
      m_idle = 1'b1;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    int k, r, c, s;
    int e_clk, e_rgb1, e_rgb2, e_latch, e_oe, e_row, e_fd, e_col, e_raddr;
    bit sh, pb;
    if (m_valid) begin
      e_clk = 0; e_rgb1 = 0; e_rgb2 = 0; e_latch = 0; e_oe = 1;
      e_row = 0; e_fd = 0; e_col = 0; e_raddr = 0;
      if (!m_idle) begin
        r  = (m_t / P) % ROWS;
        k  = m_t % P;
        sh = (k >= 1) && (k <= 2 * W);
        s  = k - 1;
        c  = s / 2;
        pb = (s % 2) == 1;
        e_clk   = (sh && pb) ? 1 : 0;
        if (sh) begin
          if (pb) begin
            e_rgb1 = f1(r, c);
            e_rgb2 = f2(r, c);
          end else if (c > 0) begin
            e_rgb1 = f1(r, c - 1);
            e_rgb2 = f2(r, c - 1);
          end
        end
        e_latch = (k == 2 * W + 2) ? 1 : 0;
        e_oe    = (k >= 2 * W + 3) ? 0 : 1;
        e_row   = (m_t < 2 * W + 3) ? 0 : ((m_t - (2 * W + 3)) / P) % ROWS;
        e_fd    = (k == P - 1 && r == ROWS - 1) ? 1 : 0;
        if (k == 0) e_col = 0;
        else if (sh) e_col = pb ? ((c + 1 < W) ? c + 1 : W - 1) : c;
        else e_col = W - 1;
        e_raddr = r;
      end
      if (mask_en) begin
        e_clk = int'(init_clk); e_rgb1 = int'(init_rgb1); e_rgb2 = int'(init_rgb2);
        e_latch = int'(init_latch); e_oe = 1;
      end
      chk("clk_out",    int'(clk_out),    e_clk);
      chk("rgb1_out",   int'(rgb1_out),   e_rgb1);
      chk("rgb2_out",   int'(rgb2_out),   e_rgb2);
      chk("latch_out",  int'(latch_out),  e_latch);
      chk("oe_n_out",   int'(oe_n_out),   e_oe);
      chk("row_out",    int'(row_out),    e_row);
      chk("frame_done", int'(frame_done), e_fd);
      chk("col_addr",   int'(col_addr),   e_col);
      chk("row_addr",   int'(row_addr),   e_raddr);

      if (!mask_en) begin
        if (clk_out && !prev_clk) rise_q.push_back(int'(rgb1_out));
        if (latch_out) latch_q.push_back(ecnt);
        if (!oe_n_out) oe_low++;
      end
      if (frame_done) fd_q.push_back(ecnt);
      prev_clk = clk_out;
    end
  end

  always @(negedge clk) begin
    if (!rst_d) begin
      if (frame_done_d) dfd_q.push_back(ecnt);
      if (row_out_d != prev_drow) drow_q.push_back(ecnt);
      prev_drow = row_out_d;
    end
  end

  initial begin
    int e0;
    reset = 1'b1; mask_en = 1'b1; rst_d = 1'b1; mask_en_d = 1'b0;
    init_rgb1 = '0; init_rgb2 = '0; init_latch = 1'b0; init_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe_n", int'(oe_n_out), 1);
    chk("reset_row_out", int'(row_out), 0);
    chk("reset_col_addr", int'(col_addr), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    reset = 1'b0; rst_d = 1'b0;

    init_rgb1 = 3'b101; init_rgb2 = 3'b010; init_latch = 1'b1; init_clk = 1'b0;
    #1;
    chk("pass_rgb1", int'(rgb1_out), 5);
    chk("pass_rgb2", int'(rgb2_out), 2);
    chk("pass_latch", int'(latch_out), 1);
    chk("pass_oe_n", int'(oe_n_out), 1);
    @(posedge clk); #1;
    init_rgb1 = 3'b011; init_latch = 1'b0; init_clk = 1'b1;
    #1;
    chk("pass_rgb1_b", int'(rgb1_out), 3);
    chk("pass_clk", int'(clk_out), 1);
    chk("pass_latch_b", int'(latch_out), 0);
    init_clk = 1'b0;

    // Scan two rows and a frame boundary.
    @(posedge clk); #1 mask_en = 1'b0;
    @(posedge clk); #1;
    e0 = ecnt;
    rise_q.delete(); latch_q.delete(); fd_q.delete(); oe_low = 0;
    repeat (13) @(posedge clk); #1;
    chk("row0_display_row_out", int'(row_out), 0);
    repeat (6) @(posedge clk); #1;
    chk("row0_oe_low_cycles", oe_low, 8);
    chk("row0_clk_rises", rise_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("row0_shift_rgb1", qv(rise_q, i), i);
    chk("first_latch_cycle", qv(latch_q, 0) - e0, 10);
    repeat (13) @(posedge clk); #1;
    chk("row1_display_row_out", int'(row_out), 1);
    repeat (19) @(posedge clk); #1;
    chk("wrap_display_row_out", int'(row_out), 0);
    repeat (25) @(posedge clk); #1;
    chk("frame_done_count", fd_q.size(), 2);
    chk("first_frame_done_cycle", qv(fd_q, 0) - e0, 37);
    chk("frame_done_spacing", qv(fd_q, 1) - qv(fd_q, 0), 38);
    chk("row_period", qv(latch_q, 1) - qv(latch_q, 0), 19);

    // Mask raised mid-SHIFT of row 1, column 2.
    mask_en = 1'b1;
    repeat (2) @(posedge clk); #1 mask_en = 1'b0;
    @(posedge clk); #1;
    repeat (24) @(posedge clk); #1;
    chk("mid_shift_col_addr", int'(col_addr), 2);
    chk("mid_shift_row_addr", int'(row_addr), 1);
    init_rgb1 = 3'b110; init_latch = 1'b1; mask_en = 1'b1;
    #1;
    chk("mask_now_rgb1", int'(rgb1_out), 6);
    chk("mask_now_latch", int'(latch_out), 1);
    chk("mask_now_oe_n", int'(oe_n_out), 1);
    @(posedge clk); #1;
    chk("mask_next_col_addr", int'(col_addr), 0);
    chk("mask_next_row_out", int'(row_out), 0);
    init_latch = 1'b0; mask_en = 1'b0;
    @(posedge clk); #1;
    e0 = ecnt;
    chk("restart_row_addr", int'(row_addr), 0);
    chk("restart_col_addr", int'(col_addr), 0);
    chk("restart_oe_n", int'(oe_n_out), 1);

    // Reset in the last-but-one DISPLAY cycle of row 1.
    repeat (36) @(posedge clk); #1;
    chk("pre_reset_row_out", int'(row_out), 1);
    chk("pre_reset_oe_n", int'(oe_n_out), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_oe_n", int'(oe_n_out), 1);
    chk("post_reset_row_out", int'(row_out), 0);
    chk("post_reset_col_addr", int'(col_addr), 0);
    chk("post_reset_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    repeat (25) @(posedge clk); #1;

    // Default-size timing.
    for (int i = 0; i < 14000 && dfd_q.size() < 2; i++) @(posedge clk);
    #1;
    chk("default_frame_done_seen", (dfd_q.size() >= 2) ? 1 : 0, 1);
    chk("default_frame_period", qv(dfd_q, 1) - qv(dfd_q, 0), 6192);
    chk("default_row_period", qv(drow_q, 1) - qv(drow_q, 0), 387);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
